// File: rtl/dsram_port_arbiter.sv
// Purpose: shares one single-port data SRAM between the instruction-fetch
// port (I, read-only) and the MEM-stage data port (D, read/write). One SRAM
// access is issued at a time. Read data is returned to the owning port after
// RD_LAT cycles, with a one-cycle valid strobe.
//
// Ports:
//   clk, reset (async, active-low)
//   i_req/i_addr -> i_gnt, i_rvalid, i_rdata               fetch read port
//   d_req/d_we/d_addr/d_wdata -> d_gnt, d_rvalid, d_rdata  data port
//   sram_en/sram_wen/sram_addr/sram_wdata, sram_rdata      SRAM bus
//   busy                                                   read outstanding
//
// Configuration macro: ARB_RR_EN selects round-robin arbitration. When it is
// undefined, arbitration is fixed priority with D above I.
//
// Grants and SRAM controls are combinational from the requests in IDLE. This
// lets a granted access reach the SRAM in the same cycle. Every output is
// forced to 0 while reset is low.

module dsram_port_arbiter #(
  parameter int unsigned AW     = 32,
  parameter int unsigned DW     = 32,
  parameter int unsigned RD_LAT = 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          i_req,
  input  logic [AW-1:0] i_addr,
  output logic          i_gnt,
  output logic          i_rvalid,
  output logic [DW-1:0] i_rdata,
  input  logic          d_req,
  input  logic [3:0]    d_we,
  input  logic [AW-1:0] d_addr,
  input  logic [DW-1:0] d_wdata,
  output logic          d_gnt,
  output logic          d_rvalid,
  output logic [DW-1:0] d_rdata,
  output logic          sram_en,
  output logic [3:0]    sram_wen,
  output logic [AW-1:0] sram_addr,
  output logic [DW-1:0] sram_wdata,
  input  logic [DW-1:0] sram_rdata,
  output logic          busy
);

  localparam int unsigned CNT_W = 2;
  localparam logic [CNT_W-1:0] LAT_INIT = CNT_W'(RD_LAT - 1);

  typedef enum logic {ST_IDLE = 1'b0, ST_WAIT = 1'b1} state_e;
  typedef enum logic {PORT_I = 1'b0, PORT_D = 1'b1} port_e;

  state_e           state_q, state_d;
  port_e            owner_q, owner_d;
  logic [CNT_W-1:0] lat_cnt_q, lat_cnt_d;
  logic             d_wins_c, i_wins_c;

`ifdef ARB_RR_EN
  port_e            last_q, last_d;

  // Round robin: on a tie, the port that was not granted last wins.
  always_comb begin
    d_wins_c = d_req && (!i_req || (last_q == PORT_I));
    i_wins_c = i_req && !d_wins_c;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      last_q <= PORT_I;
    end else begin
      last_q <= last_d;
    end
  end
`else
  // Fixed priority: D always beats I.
  always_comb begin
    d_wins_c = d_req;
    i_wins_c = i_req && !d_req;
  end
`endif

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= ST_IDLE;
      owner_q   <= PORT_D;
      lat_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      owner_q   <= owner_d;
      lat_cnt_q <= lat_cnt_d;
    end
  end

  // Next state and outputs.
  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    lat_cnt_d  = lat_cnt_q;
`ifdef ARB_RR_EN
    last_d     = last_q;
`endif
    i_gnt      = 1'b0;
    i_rvalid   = 1'b0;
    i_rdata    = '0;
    d_gnt      = 1'b0;
    d_rvalid   = 1'b0;
    d_rdata    = '0;
    sram_en    = 1'b0;
    sram_wen   = 4'b0000;
    sram_addr  = '0;
    sram_wdata = '0;
    busy       = 1'b0;

    if (reset) begin
      case (state_q)
        ST_IDLE: begin
          if (d_wins_c) begin
            d_gnt      = 1'b1;
            sram_en    = 1'b1;
            sram_wen   = d_we;
            sram_addr  = d_addr;
            sram_wdata = d_wdata;
`ifdef ARB_RR_EN
            last_d     = PORT_D;
`endif
            // A write completes at the edge and needs no return path.
            if (d_we == 4'b0000) begin
              state_d   = ST_WAIT;
              owner_d   = PORT_D;
              lat_cnt_d = LAT_INIT;
            end
          end else if (i_wins_c) begin
            i_gnt     = 1'b1;
            sram_en   = 1'b1;
            sram_addr = i_addr;
`ifdef ARB_RR_EN
            last_d    = PORT_I;
`endif
            state_d   = ST_WAIT;
            owner_d   = PORT_I;
            lat_cnt_d = LAT_INIT;
          end
        end
        ST_WAIT: begin
          busy = 1'b1;
          if (lat_cnt_q == '0) begin
            if (owner_q == PORT_D) begin
              d_rvalid = 1'b1;
              d_rdata  = sram_rdata;
            end else begin
              i_rvalid = 1'b1;
              i_rdata  = sram_rdata;
            end
            state_d = ST_IDLE;
          end else begin
            lat_cnt_d = lat_cnt_q - CNT_W'(1);
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

endmodule
